ctrl_seq: RTL and testbench

Sequential, parametrised successor to the combinational control decoder: it registers the decode of the fetched instruction and adds a run/stall/halt state machine. It drives the fetch unit's PC enable, and stalls fetch for multi-cycle LOAD/STORE memory accesses. It also latches HALT into a sticky Done flag and flags undefined type-I sub-opcodes. It sits between instruction ROM and program_counter/ALU/data memory.

---
 rtl/ctrl_seq.sv | 168 ++++++++++++++++
 tb/tb_ctrl_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// Sequential control unit: registered instruction decode plus a run/stall/halt
// state machine that gates the fetch unit's PC and stretches LOAD/STORE accesses.
module ctrl_seq #(
  parameter int IW      = 9,
  parameter int OPW     = 5,
  parameter int MEM_LAT = 2
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           InstValid,
  input  logic [IW-1:0]  Instruction,
  output logic           PcEn,
  output logic           Jump,
  output logic           BranchEn,
  output logic           WriteR,
  output logic           ImmMux,
  output logic [OPW-1:0] OP,
  output logic [IW-8:0]  Operand,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           Illegal,
  output logic           Done
);

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_MOVER = OPW'(2);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(8);
  localparam logic [OPW-1:0] OP_STORE = OPW'(9);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(10);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(11);
  localparam logic [OPW-1:0] OP_BLT   = OPW'(12);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(13);
  localparam logic [OPW-1:0] OP_LSR   = OPW'(17);
  localparam logic [OPW-1:0] OP_RSR   = OPW'(18);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM, S_HALTED} state_t;

  state_t     state_reg;
  logic [3:0] cnt_reg;

  logic [1:0]     inst_type;
  logic [3:0]     sub_op;
  logic [OPW-1:0] dec_op;
  logic           dec_jump, dec_branch, dec_writer, dec_imm, dec_illegal;
  logic           dec_load, dec_store, dec_halt;

  assign inst_type = Instruction[IW-1:IW-2];
  assign sub_op    = Instruction[IW-3:IW-6];

  always_comb begin
    dec_op      = OP_NOP;
    dec_jump    = 1'b0;
    dec_branch  = 1'b0;
    dec_writer  = 1'b0;
    dec_imm     = 1'b0;
    dec_illegal = 1'b0;
    case (inst_type)
      2'b00: begin
        if (sub_op <= 4'd9) dec_op = OPW'(sub_op) + OPW'(1);
        else                dec_illegal = 1'b1;
      end
      2'b01: begin
        dec_branch = 1'b1;
        dec_op     = Instruction[IW-3] ? OP_BLT : OP_BEQ;
      end
      2'b10: begin
        dec_imm  = 1'b1;
        dec_op   = OP_ANDI + OPW'(Instruction[IW-3:IW-4]);
        dec_jump = (Instruction[IW-3:IW-4] == 2'b11);
      end
      default: begin
        dec_writer = 1'b1;
        dec_op     = Instruction[IW-3] ? OP_RSR : OP_LSR;
      end
    endcase
    if (dec_op == OP_MOVER) dec_writer = 1'b1;
  end

  assign dec_load  = (dec_op == OP_LOAD);
  assign dec_store = (dec_op == OP_STORE);
  assign dec_halt  = (dec_op == OP_HALT);

  // PC may advance on a plain accepted instruction, or on the last MEM cycle.
  always_comb begin
    PcEn = 1'b0;
    if (!Reset) begin
      case (state_reg)
        S_RUN:   PcEn = InstValid && !dec_load && !dec_store && !dec_halt;
        S_MEM:   PcEn = (cnt_reg == 4'd0);
        default: PcEn = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
      OP        <= OP_NOP;
      Operand   <= '0;
      Jump      <= 1'b0;
      BranchEn  <= 1'b0;
      WriteR    <= 1'b0;
      ImmMux    <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Illegal   <= 1'b0;
      Done      <= 1'b0;
    end else begin
      // Outside MEM every cycle defaults to a NOP bubble; MEM holds everything.
      if (state_reg != S_MEM) begin
        OP       <= OP_NOP;
        Operand  <= '0;
        Jump     <= 1'b0;
        BranchEn <= 1'b0;
        WriteR   <= 1'b0;
        ImmMux   <= 1'b0;
        MemRead  <= 1'b0;
        MemWrite <= 1'b0;
        Illegal  <= 1'b0;
      end
      case (state_reg)
        S_IDLE: begin
          if (Start) state_reg <= S_RUN;
        end
        S_RUN: begin
          if (InstValid) begin
            OP       <= dec_op;
            Operand  <= Instruction[IW-8:0];
            Jump     <= dec_jump;
            BranchEn <= dec_branch;
            WriteR   <= dec_writer;
            ImmMux   <= dec_imm;
            Illegal  <= dec_illegal;
            if (dec_load || dec_store) begin
              MemRead   <= dec_load;
              MemWrite  <= dec_store;
              cnt_reg   <= 4'(MEM_LAT - 1);
              state_reg <= S_MEM;
            end else if (dec_halt) begin
              Done      <= 1'b1;
              state_reg <= S_HALTED;
            end
          end
        end
        S_MEM: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= S_RUN;
            OP        <= OP_NOP;
            Operand   <= '0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
          if (Start) begin
            state_reg <= S_RUN;
            Done      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomised bench for ctrl_seq: a cycle-level reference model queues expected
// PcEn and registered outputs; two monitors pop and compare them.
module tb_ctrl_seq;

  localparam int IW = 9;
  localparam int OPW = 5;
  localparam int MEM_LAT = 2;
  localparam int OW = OPW + (IW - 7) + 8;

  localparam int M_IDLE = 0, M_RUN = 1, M_MEM = 2, M_HALTED = 3;

  logic Clk, Reset, Start, InstValid;
  logic [IW-1:0] Instruction;
  logic PcEn, Jump, BranchEn, WriteR, ImmMux, MemRead, MemWrite, Illegal, Done;
  logic [OPW-1:0] OP;
  logic [IW-8:0] Operand;

  ctrl_seq #(.IW(IW), .OPW(OPW), .MEM_LAT(MEM_LAT)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstValid(InstValid),
    .Instruction(Instruction), .PcEn(PcEn), .Jump(Jump), .BranchEn(BranchEn),
    .WriteR(WriteR), .ImmMux(ImmMux), .OP(OP), .Operand(Operand),
    .MemRead(MemRead), .MemWrite(MemWrite), .Illegal(Illegal), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int fails = 0;
  int cycle = 0;

  bit          pc_q[$];
  logic [OW-1:0] out_q[$];

  // Reference model state
  int m_mode = M_IDLE;
  int m_left = 0;
  bit m_done = 0;
  logic [OW-1:0] m_out = '0;

  wire [OW-1:0] dut_out = {OP, Operand, Jump, BranchEn, WriteR, ImmMux,
                           MemRead, MemWrite, Illegal, Done};

  task automatic model_step(input bit rst, input bit st, input bit iv, input logic [IW-1:0] ins);
    bit pc, j, b, w, im, mr, mw, il, dn, hold;
    int op;
    logic [IW-8:0] opd;
    logic [OW-1:0] e;
    pc = 0; j = 0; b = 0; w = 0; im = 0; mr = 0; mw = 0; il = 0; hold = 0;
    op = 0; opd = '0; dn = m_done;
    if (rst) begin
      m_mode = M_IDLE; dn = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (st) m_mode = M_RUN;
        M_RUN: if (iv) begin
          opd = ins[IW-8:0];
          case (ins[8:7])
            2'd0: begin
              if (ins[6:3] <= 4'd9) op = int'(ins[6:3]) + 1;
              else il = 1;
              w = (op == 2);
            end
            2'd1: begin b = 1; op = ins[6] ? 12 : 11; end
            2'd2: begin im = 1; op = 13 + int'(ins[6:5]); j = (op == 16); end
            default: begin w = 1; op = ins[6] ? 18 : 17; end
          endcase
          if (op == 8 || op == 9) begin
            mr = (op == 8); mw = (op == 9);
            m_mode = M_MEM; m_left = MEM_LAT - 1;
          end else if (op == 10) begin
            dn = 1; m_mode = M_HALTED;
          end else begin
            pc = 1;
          end
        end
        M_MEM: begin
          pc = (m_left == 0);
          if (m_left == 0) m_mode = M_RUN;
          else begin m_left--; hold = 1; end
        end
        default: if (st) begin m_mode = M_RUN; dn = 0; end
      endcase
    end
    e = hold ? m_out : {OPW'(op), opd, j, b, w, im, mr, mw, il, dn};
    m_out = e;
    m_done = dn;
    pc_q.push_back(pc);
    out_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit st, input bit iv, input logic [IW-1:0] ins);
    @(negedge Clk);
    Reset = rst; Start = st; InstValid = iv; Instruction = ins;
    cycle++;
    model_step(rst, st, iv, ins);
  endtask

  // PcEn is combinational: check mid-cycle, after the inputs settle
  initial begin
    bit e;
    forever begin
      @(negedge Clk); #1;
      if (pc_q.size() > 0) begin
        e = pc_q.pop_front();
        checks++;
        if (PcEn !== e) begin
          fails++;
          $display("FAIL pcen cycle %0d: got %b expected %b", cycle, PcEn, e);
        end
      end
    end
  end

  initial begin
    logic [OW-1:0] e;
    forever begin
      @(posedge Clk); #1;
      if (out_q.size() > 0) begin
        e = out_q.pop_front();
        checks++;
        if (dut_out !== e)
          begin
            fails++;
            $display("FAIL outs cycle %0d: got op=%0d opd=%b flags(j,b,w,im,mr,mw,il,dn)=%b expected op=%0d opd=%b flags=%b",
                     cycle, dut_out[OW-1 -: OPW], dut_out[IW-8+8:8], dut_out[7:0],
                     e[OW-1 -: OPW], e[IW-8+8:8], e[7:0]);
          end
        else
          $display("cycle %0d: PcEn=%b OP=%0d Operand=%b flags=%b ok", cycle, PcEn, OP, Operand, dut_out[7:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] r;
    Reset = 1; Start = 0; InstValid = 0; Instruction = '0;
    // Reset mid-stream, start, then directed sequences
    cyc(1, 0, 1, 9'b000000101);
    cyc(1, 1, 1, 9'b000000101);
    cyc(0, 0, 0, 9'b0);
    cyc(0, 1, 0, 9'b0);
    cyc(0, 0, 1, 9'b000000011);   // ADD
    cyc(0, 0, 1, 9'b101101010);   // JUMP
    cyc(0, 0, 1, 9'b111000001);   // RSR
    cyc(0, 0, 1, 9'b000111010);   // LOAD
    cyc(0, 0, 1, 9'b000000001);   // ignored in MEM
    cyc(0, 0, 1, 9'b001000000);   // ignored in MEM
    cyc(0, 0, 1, 9'b001100011);   // illegal sub-op 12
    cyc(0, 0, 1, 9'b000000010);   // ADD
    cyc(0, 0, 0, 9'b0);           // bubble
    cyc(0, 0, 1, 9'b001001000);   // HALT
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 9'(($urandom)));
    cyc(0, 1, 0, 9'b0);           // Start from HALTED
    cyc(0, 0, 1, 9'b001000011);   // STORE
    cyc(1, 0, 1, 9'b000000000);   // reset one cycle into MEM
    cyc(0, 0, 1, 9'b000000001);   // idle, no Start yet
    cyc(0, 0, 1, 9'b000000001);
    cyc(0, 1, 0, 9'b0);
    cyc(0, 0, 1, 9'b011000010);   // BLT
    cyc(0, 0, 1, 9'b100100001);   // ADDI
    // Randomised stream
    for (int i = 0; i < 3000; i++) begin
      r = 9'($urandom);
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0), r);
    end
    cyc(0, 0, 0, 9'b0);
    repeat (2) @(posedge Clk);
    #3;
    checks++;
    if (pc_q.size() != 0 || out_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending expectations, required 0/0", pc_q.size(), out_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
